// File: rtl/cpu_pipe_ctrl.sv
// Pipelined ID-stage control: decodes into a registered EX bundle, detects load-use
// hazards, selects the next PC and sequences prioritised interrupts and exceptions.
module cpu_pipe_ctrl #(
  parameter int unsigned NUM_IRQ   = 4,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               ex_memrd,
  input  logic [4:0]         ex_rt,
  input  logic               ex_br_taken,
  input  logic               pc_kernel,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic               stall,
  output logic               flush_if,
  output logic [2:0]         pcsrc,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [1:0]         exc_cause,
  output logic               ex_regwr,
  output logic               ex_memwr,
  output logic               ex_memrd_o,
  output logic               ex_alusrc1,
  output logic               ex_alusrc2,
  output logic               ex_sign,
  output logic               ex_extop,
  output logic               ex_luop,
  output logic [1:0]         ex_regdst,
  output logic [1:0]         ex_memtoreg,
  output logic [5:0]         ex_alufun
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [5:0] ALU_ADD = 6'b000000, ALU_SUB = 6'b000001, ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110, ALU_XOR = 6'b010110, ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000, ALU_SRL = 6'b100001, ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011, ALU_NEQ = 6'b110001, ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101, ALU_GTZ = 6'b111111, ALU_LTZ = 6'b111011;

  typedef struct packed {
    logic       regwr;
    logic       memwr;
    logic       memrd;
    logic       alusrc1;
    logic       alusrc2;
    logic       sign;
    logic       extop;
    logic       luop;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [5:0] alufun;
  } ctrl_t;

  typedef enum logic [1:0] {IDLE, ARM, TAKE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, pend_idx;
  ctrl_t            ctrl_q, ctrl_d, dec;
  logic [1:0]       cause_q, cause_d;
  logic             dec_ok, is_j, is_jr;
  logic             hazard_c, exc_c, take_c, jump_c;
  logic [NUM_IRQ-1:0] pend;

  // Instruction decode; unknown encodings clear dec_ok and yield an all-zero bundle
  always_comb begin
    dec       = '0;
    dec.sign  = 1'b1;
    dec.extop = 1'b1;
    dec_ok    = 1'b1;
    is_j      = 1'b0;
    is_jr     = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec.regwr = 1'b1; dec.alufun = ALU_ADD; end
          6'h21: begin dec.regwr = 1'b1; dec.alufun = ALU_ADD; dec.sign = 1'b0; end
          6'h22: begin dec.regwr = 1'b1; dec.alufun = ALU_SUB; end
          6'h23: begin dec.regwr = 1'b1; dec.alufun = ALU_SUB; dec.sign = 1'b0; end
          6'h24: begin dec.regwr = 1'b1; dec.alufun = ALU_AND; end
          6'h25: begin dec.regwr = 1'b1; dec.alufun = ALU_OR;  end
          6'h26: begin dec.regwr = 1'b1; dec.alufun = ALU_XOR; end
          6'h27: begin dec.regwr = 1'b1; dec.alufun = ALU_NOR; end
          6'h2A: begin dec.regwr = 1'b1; dec.alufun = ALU_LT;  end
          6'h00: begin dec.regwr = 1'b1; dec.alufun = ALU_SLL; dec.alusrc1 = 1'b1; end
          6'h02: begin dec.regwr = 1'b1; dec.alufun = ALU_SRL; dec.alusrc1 = 1'b1; end
          6'h03: begin dec.regwr = 1'b1; dec.alufun = ALU_SRA; end
          6'h08: is_jr = 1'b1;
          6'h09: begin
            is_jr = 1'b1; dec.regwr = 1'b1; dec.regdst = 2'b10; dec.memtoreg = 2'b10;
          end
          default: dec_ok = 1'b0;
        endcase
      end
      6'h23: begin
        dec.regwr = 1'b1; dec.regdst = 2'b01; dec.memrd = 1'b1;
        dec.memtoreg = 2'b01; dec.alusrc2 = 1'b1;
      end
      6'h2B: begin dec.memwr = 1'b1; dec.alusrc2 = 1'b1; end
      6'h0F: begin dec.regwr = 1'b1; dec.regdst = 2'b01; dec.alusrc2 = 1'b1; dec.luop = 1'b1; end
      6'h08: begin dec.regwr = 1'b1; dec.regdst = 2'b01; dec.alusrc2 = 1'b1; end
      6'h09: begin dec.regwr = 1'b1; dec.regdst = 2'b01; dec.alusrc2 = 1'b1; dec.sign = 1'b0; end
      6'h0C: begin
        dec.regwr = 1'b1; dec.regdst = 2'b01; dec.alusrc2 = 1'b1;
        dec.alufun = ALU_AND; dec.extop = 1'b0;
      end
      6'h0A: begin dec.regwr = 1'b1; dec.regdst = 2'b01; dec.alusrc2 = 1'b1; dec.alufun = ALU_LT; end
      6'h0B: begin
        dec.regwr = 1'b1; dec.regdst = 2'b01; dec.alusrc2 = 1'b1;
        dec.alufun = ALU_LT; dec.sign = 1'b0;
      end
      6'h04: dec.alufun = ALU_EQ;
      6'h05: dec.alufun = ALU_NEQ;
      6'h06: dec.alufun = ALU_LEZ;
      6'h07: dec.alufun = ALU_GTZ;
      6'h01: dec.alufun = ALU_LTZ;
      6'h02: is_j = 1'b1;
      6'h03: begin is_j = 1'b1; dec.regwr = 1'b1; dec.regdst = 2'b10; dec.memtoreg = 2'b10; end
      default: dec_ok = 1'b0;
    endcase
    if (!dec_ok) dec = '0;
  end

  // Lowest-index unmasked request wins
  always_comb begin
    pend     = irq & ~irq_mask;
    pend_idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pend[i]) pend_idx = IDX_W'(i);
    end
  end

  // Hazard, trap, redirect and next-state logic
  always_comb begin
    hazard_c = HAZARD_EN && ex_memrd && id_valid && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (ex_rt == id_rt));
    exc_c    = id_valid && !dec_ok && !pc_kernel && !hazard_c && !ex_br_taken;
    take_c   = (state_q == TAKE) && !ex_br_taken && !exc_c;
    jump_c   = id_valid && (is_j || is_jr) && !hazard_c && !ex_br_taken && !take_c;

    stall    = hazard_c && !reset;
    flush_if = !reset && (ex_br_taken || exc_c || take_c || jump_c);
    irq_ack  = (!reset && take_c) ? (NUM_IRQ'(1) << idx_q) : '0;
    if (reset)            pcsrc = 3'b000;
    else if (ex_br_taken) pcsrc = 3'b001;
    else if (exc_c)       pcsrc = 3'b101;
    else if (take_c)      pcsrc = 3'b100;
    else if (jump_c)      pcsrc = is_jr ? 3'b011 : 3'b010;
    else                  pcsrc = 3'b000;

    ctrl_d = '0;
    if (exc_c || take_c) begin
      ctrl_d.regwr    = 1'b1;
      ctrl_d.regdst   = 2'b11;
      ctrl_d.memtoreg = 2'b10;
    end else if (id_valid && !hazard_c && !ex_br_taken) begin
      ctrl_d = dec;
    end

    cause_d = cause_q;
    if (exc_c)       cause_d = 2'd1;
    else if (take_c) cause_d = 2'd2;

    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if ((|pend) && !pc_kernel) begin state_d = ARM; idx_d = pend_idx; end
      ARM:  if (id_valid && !hazard_c && !ex_br_taken && !exc_c) state_d = TAKE;
      TAKE: state_d = take_c ? IDLE : ARM;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ctrl_q  <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
      cause_q <= cause_d;
    end
  end

  assign exc_cause   = cause_q;
  assign ex_regwr    = ctrl_q.regwr;
  assign ex_memwr    = ctrl_q.memwr;
  assign ex_memrd_o  = ctrl_q.memrd;
  assign ex_alusrc1  = ctrl_q.alusrc1;
  assign ex_alusrc2  = ctrl_q.alusrc2;
  assign ex_sign     = ctrl_q.sign;
  assign ex_extop    = ctrl_q.extop;
  assign ex_luop     = ctrl_q.luop;
  assign ex_regdst   = ctrl_q.regdst;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_alufun   = ctrl_q.alufun;

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Bench for cpu_pipe_ctrl: one interlocked and one non-interlocked instance driven together,
// both compared every cycle against an instruction-table reference model.
module tb_cpu_pipe_ctrl;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_J = 5, K_JR = 6;
  localparam logic [17:0] TRAP = 18'b1_0_0_0_0_0_0_0_11_10_000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, ex_memrd, ex_br_taken, pc_kernel;
  logic [5:0] opcode, funct;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic [3:0] irq, irq_mask;

  logic       stall_a, flush_a, regwr_a, memwr_a, memrd_a, src1_a, src2_a, sign_a, extop_a, luop_a;
  logic [2:0] pcsrc_a;
  logic [3:0] ack_a;
  logic [1:0] cause_a, regdst_a, memtoreg_a;
  logic [5:0] alufun_a;
  logic       stall_b, flush_b, regwr_b, memwr_b, memrd_b, src1_b, src2_b, sign_b, extop_b, luop_b;
  logic [2:0] pcsrc_b;
  logic [3:0] ack_b;
  logic [1:0] cause_b, regdst_b, memtoreg_b;
  logic [5:0] alufun_b;
  logic [17:0] bun_a, bun_b;

  assign bun_a = {regwr_a, memwr_a, memrd_a, src1_a, src2_a, sign_a, extop_a, luop_a,
                  regdst_a, memtoreg_a, alufun_a};
  assign bun_b = {regwr_b, memwr_b, memrd_b, src1_b, src2_b, sign_b, extop_b, luop_b,
                  regdst_b, memtoreg_b, alufun_b};

  cpu_pipe_ctrl #(.NUM_IRQ(4), .HAZARD_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memrd(ex_memrd), .ex_rt(ex_rt),
    .ex_br_taken(ex_br_taken), .pc_kernel(pc_kernel), .irq(irq), .irq_mask(irq_mask),
    .stall(stall_a), .flush_if(flush_a), .pcsrc(pcsrc_a), .irq_ack(ack_a),
    .exc_cause(cause_a), .ex_regwr(regwr_a), .ex_memwr(memwr_a), .ex_memrd_o(memrd_a),
    .ex_alusrc1(src1_a), .ex_alusrc2(src2_a), .ex_sign(sign_a), .ex_extop(extop_a),
    .ex_luop(luop_a), .ex_regdst(regdst_a), .ex_memtoreg(memtoreg_a), .ex_alufun(alufun_a));

  cpu_pipe_ctrl #(.NUM_IRQ(4), .HAZARD_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memrd(ex_memrd), .ex_rt(ex_rt),
    .ex_br_taken(ex_br_taken), .pc_kernel(pc_kernel), .irq(irq), .irq_mask(irq_mask),
    .stall(stall_b), .flush_if(flush_b), .pcsrc(pcsrc_b), .irq_ack(ack_b),
    .exc_cause(cause_b), .ex_regwr(regwr_b), .ex_memwr(memwr_b), .ex_memrd_o(memrd_b),
    .ex_alusrc1(src1_b), .ex_alusrc2(src2_b), .ex_sign(sign_b), .ex_extop(extop_b),
    .ex_luop(luop_b), .ex_regdst(regdst_b), .ex_memtoreg(memtoreg_b), .ex_alufun(alufun_b));

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [5:0] alu;
    int         kind;
    bit         uns, link, shamt, zext, lu;
  } desc_t;

  desc_t tbl[$];
  int n_assert, n_fail;

  // Model state per instance: 0 = interlocked, 1 = no interlock
  int          ms[2], midx[2], ns[2], nidx[2];
  logic [17:0] mb[2], nb[2];
  logic [1:0]  mc[2], nc[2];
  logic        e_stall[2], e_flush[2];
  logic [2:0]  e_pc[2];
  logic [3:0]  e_ack[2];

  task automatic def(input logic [5:0] op, input logic [5:0] fn, input logic [5:0] alu,
                     input int kind, input bit uns, input bit link, input bit shamt,
                     input bit zext, input bit lu);
    desc_t d;
    d.op = op; d.fn = fn; d.alu = alu; d.kind = kind;
    d.uns = uns; d.link = link; d.shamt = shamt; d.zext = zext; d.lu = lu;
    tbl.push_back(d);
  endtask

  function automatic bit lookup(input logic [5:0] op, input logic [5:0] fn, output desc_t d);
    d = tbl[0];
    foreach (tbl[i]) begin
      if ((tbl[i].op == 6'd0 && op == 6'd0 && fn == tbl[i].fn) ||
          (tbl[i].op != 6'd0 && op == tbl[i].op)) begin
        d = tbl[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [17:0] ctl(input desc_t d);
    logic wr, s2;
    logic [1:0] rd, mr;
    wr = (d.kind == K_R) || (d.kind == K_I) || (d.kind == K_LW) || d.link;
    s2 = (d.kind == K_I) || (d.kind == K_LW) || (d.kind == K_SW);
    rd = d.link ? 2'd2 : ((d.kind == K_I) || (d.kind == K_LW)) ? 2'd1 : 2'd0;
    mr = (d.kind == K_LW) ? 2'd1 : d.link ? 2'd2 : 2'd0;
    return {wr, d.kind == K_SW, d.kind == K_LW, d.shamt, s2, ~d.uns, ~d.zext, d.lu, rd, mr, d.alu};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    desc_t d;
    bit f, st, exc, tk, jp, got;
    logic [3:0] pend;
    f = lookup(opcode, funct, d);
    for (int h = 0; h < 2; h++) begin
      if (reset) begin
        e_stall[h] = 0; e_flush[h] = 0; e_pc[h] = 0; e_ack[h] = 0;
        ns[h] = 0; nidx[h] = 0; nb[h] = 0; nc[h] = 0;
        continue;
      end
      st  = (h == 0) && ex_memrd && id_valid && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
      exc = id_valid && !f && !pc_kernel && !st && !ex_br_taken;
      tk  = (ms[h] == 2) && !ex_br_taken && !exc;
      jp  = id_valid && f && (d.kind == K_J || d.kind == K_JR) && !st && !ex_br_taken && !tk;
      e_stall[h] = st;
      e_flush[h] = ex_br_taken || exc || tk || jp;
      e_pc[h]    = ex_br_taken ? 3'd1 : exc ? 3'd5 : tk ? 3'd4 :
                   jp ? ((d.kind == K_J) ? 3'd2 : 3'd3) : 3'd0;
      e_ack[h]   = tk ? 4'(1 << midx[h]) : 4'd0;
      nb[h] = (exc || tk) ? TRAP : (st || ex_br_taken || !id_valid || !f) ? 18'd0 : ctl(d);
      nc[h] = exc ? 2'd1 : tk ? 2'd2 : mc[h];
      ns[h] = ms[h];
      nidx[h] = midx[h];
      pend = irq & ~irq_mask;
      if (ms[h] == 0) begin
        if (pend != 0 && !pc_kernel) begin
          ns[h] = 1;
          got = 0;
          for (int i = 0; i < 4; i++) if (pend[i] && !got) begin nidx[h] = i; got = 1; end
        end
      end else if (ms[h] == 1) begin
        if (id_valid && !st && !ex_br_taken && !exc) ns[h] = 2;
      end else begin
        ns[h] = tk ? 0 : 1;
      end
    end
  endtask

  task automatic cycle();
    #1;
    model_eval();
    chk("stall_hz1",  32'(stall_a), 32'(e_stall[0]));
    chk("flush_hz1",  32'(flush_a), 32'(e_flush[0]));
    chk("pcsrc_hz1",  32'(pcsrc_a), 32'(e_pc[0]));
    chk("ack_hz1",    32'(ack_a),   32'(e_ack[0]));
    chk("bundle_hz1", 32'(bun_a),   32'(mb[0]));
    chk("cause_hz1",  32'(cause_a), 32'(mc[0]));
    chk("stall_hz0",  32'(stall_b), 32'(e_stall[1]));
    chk("flush_hz0",  32'(flush_b), 32'(e_flush[1]));
    chk("pcsrc_hz0",  32'(pcsrc_b), 32'(e_pc[1]));
    chk("ack_hz0",    32'(ack_b),   32'(e_ack[1]));
    chk("bundle_hz0", 32'(bun_b),   32'(mb[1]));
    chk("cause_hz0",  32'(cause_b), 32'(mc[1]));
    @(posedge clk);
    for (int h = 0; h < 2; h++) begin
      ms[h] = ns[h]; midx[h] = nidx[h]; mb[h] = nb[h]; mc[h] = nc[h];
    end
    @(negedge clk);
  endtask

  task automatic set_ins(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt);
    id_valid = v; opcode = op; funct = fn; id_rs = rs; id_rt = rt;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    def(6'h00, 6'h20, 6'b000000, K_R, 0, 0, 0, 0, 0);
    def(6'h00, 6'h21, 6'b000000, K_R, 1, 0, 0, 0, 0);
    def(6'h00, 6'h22, 6'b000001, K_R, 0, 0, 0, 0, 0);
    def(6'h00, 6'h23, 6'b000001, K_R, 1, 0, 0, 0, 0);
    def(6'h00, 6'h24, 6'b011000, K_R, 0, 0, 0, 0, 0);
    def(6'h00, 6'h25, 6'b011110, K_R, 0, 0, 0, 0, 0);
    def(6'h00, 6'h26, 6'b010110, K_R, 0, 0, 0, 0, 0);
    def(6'h00, 6'h27, 6'b010001, K_R, 0, 0, 0, 0, 0);
    def(6'h00, 6'h2A, 6'b110101, K_R, 0, 0, 0, 0, 0);
    def(6'h00, 6'h00, 6'b100000, K_R, 0, 0, 1, 0, 0);
    def(6'h00, 6'h02, 6'b100001, K_R, 0, 0, 1, 0, 0);
    def(6'h00, 6'h03, 6'b100011, K_R, 0, 0, 0, 0, 0);
    def(6'h00, 6'h08, 6'b000000, K_JR, 0, 0, 0, 0, 0);
    def(6'h00, 6'h09, 6'b000000, K_JR, 0, 1, 0, 0, 0);
    def(6'h23, 6'h00, 6'b000000, K_LW, 0, 0, 0, 0, 0);
    def(6'h2B, 6'h00, 6'b000000, K_SW, 0, 0, 0, 0, 0);
    def(6'h0F, 6'h00, 6'b000000, K_I, 0, 0, 0, 0, 1);
    def(6'h08, 6'h00, 6'b000000, K_I, 0, 0, 0, 0, 0);
    def(6'h09, 6'h00, 6'b000000, K_I, 1, 0, 0, 0, 0);
    def(6'h0C, 6'h00, 6'b011000, K_I, 0, 0, 0, 1, 0);
    def(6'h0A, 6'h00, 6'b110101, K_I, 0, 0, 0, 0, 0);
    def(6'h0B, 6'h00, 6'b110101, K_I, 1, 0, 0, 0, 0);
    def(6'h04, 6'h00, 6'b110011, K_BR, 0, 0, 0, 0, 0);
    def(6'h05, 6'h00, 6'b110001, K_BR, 0, 0, 0, 0, 0);
    def(6'h06, 6'h00, 6'b111101, K_BR, 0, 0, 0, 0, 0);
    def(6'h07, 6'h00, 6'b111111, K_BR, 0, 0, 0, 0, 0);
    def(6'h01, 6'h00, 6'b111011, K_BR, 0, 0, 0, 0, 0);
    def(6'h02, 6'h00, 6'b000000, K_J, 0, 0, 0, 0, 0);
    def(6'h03, 6'h00, 6'b000000, K_J, 0, 1, 0, 0, 0);
    for (int h = 0; h < 2; h++) begin ms[h] = 0; midx[h] = 0; mb[h] = 0; mc[h] = 0; end

    reset = 1; set_ins(0, 6'h00, 6'h00, 5'd0, 5'd0);
    ex_memrd = 0; ex_rt = 0; ex_br_taken = 0; pc_kernel = 0; irq = 0; irq_mask = 0;
    @(posedge clk); @(negedge clk);
    cycle();
    chk("reset_bundle", 32'(bun_a), 32'd0);
    chk("reset_cause",  32'(cause_a), 32'd0);
    reset = 0;

    // addu $3,$1,$2
    set_ins(1, 6'h00, 6'h21, 5'd1, 5'd2);
    cycle();
    chk("tp1_regwr",  32'(regwr_a),  32'd1);
    chk("tp1_regdst", 32'(regdst_a), 32'd0);
    chk("tp1_alufun", 32'(alufun_a), 32'd0);
    chk("tp1_sign",   32'(sign_a),   32'd0);

    // load-use hazard on rs
    set_ins(1, 6'h00, 6'h20, 5'd5, 5'd2); ex_memrd = 1; ex_rt = 5'd5;
    #1;
    chk("tp2_stall",      32'(stall_a), 32'd1);
    chk("tp2_stall_nohz", 32'(stall_b), 32'd0);
    cycle();
    chk("tp2_bubble",       32'(bun_a),   32'd0);
    chk("tp2_nohz_decoded", 32'(regwr_b), 32'd1);
    ex_memrd = 0;
    cycle();

    // branch taken squashes undefined instruction
    set_ins(1, 6'h3F, 6'h00, 5'd0, 5'd0); ex_br_taken = 1;
    #1;
    chk("tp3_pcsrc", 32'(pcsrc_a), 32'd1);
    chk("tp3_flush", 32'(flush_a), 32'd1);
    cycle();
    chk("tp3_cause", 32'(cause_a), 32'd0);
    ex_br_taken = 0; set_ins(1, 6'h00, 6'h21, 5'd1, 5'd2);

    // interrupt with one stalled ARM cycle
    irq = 4'b0110;
    cycle();
    irq = 0; ex_memrd = 1; ex_rt = 5'd1;
    cycle();
    ex_memrd = 0;
    cycle();
    #1;
    chk("tp4_pcsrc", 32'(pcsrc_a), 32'd4);
    chk("tp4_ack",   32'(ack_a),   32'b0010);
    cycle();
    chk("tp4_regdst",   32'(regdst_a),   32'd3);
    chk("tp4_memtoreg", 32'(memtoreg_a), 32'd2);
    chk("tp4_cause",    32'(cause_a),    32'd2);

    // undefined instruction and interrupt together
    set_ins(1, 6'h3F, 6'h00, 5'd0, 5'd0); irq = 4'b0001;
    #1;
    chk("tp5_pcsrc", 32'(pcsrc_a), 32'd5);
    chk("tp5_ack",   32'(ack_a),   32'd0);
    cycle();
    chk("tp5_cause", 32'(cause_a), 32'd1);
    irq = 0; set_ins(1, 6'h00, 6'h21, 5'd1, 5'd2);
    cycle();
    #1;
    chk("tp5_take_pcsrc", 32'(pcsrc_a), 32'd4);
    chk("tp5_take_ack",   32'(ack_a),   32'b0001);
    cycle();

    // masking selects line 2
    irq = 4'b1111; irq_mask = 4'b0011;
    cycle();
    irq = 0; irq_mask = 0;
    cycle();
    #1;
    chk("mask_ack", 32'(ack_a), 32'b0100);
    cycle();

    // kernel mode: no interrupt recognition, undefined op is a bubble
    pc_kernel = 1; irq = 4'b0001; set_ins(1, 6'h3F, 6'h00, 5'd0, 5'd0);
    #1;
    chk("kern_pcsrc", 32'(pcsrc_a), 32'd0);
    cycle();
    chk("kern_bubble", 32'(bun_a), 32'd0);
    pc_kernel = 0; irq = 0; set_ins(1, 6'h00, 6'h21, 5'd1, 5'd2);
    cycle(); cycle();

    // reset while armed
    irq = 4'b1000;
    cycle();
    irq = 0; reset = 1;
    cycle();
    chk("tp6_bundle", 32'(bun_a),   32'd0);
    chk("tp6_cause",  32'(cause_a), 32'd0);
    reset = 0;
    for (int i = 0; i < 3; i++) cycle();

    for (int n = 0; n < 600; n++) begin
      int k;
      k = $urandom_range(tbl.size() - 1);
      if ($urandom_range(99) < 85) begin
        opcode = tbl[k].op;
        funct  = (tbl[k].op == 6'd0) ? tbl[k].fn : 6'($urandom);
      end else begin
        opcode = ($urandom_range(1) == 0) ? 6'd0 : 6'($urandom);
        funct  = 6'($urandom);
      end
      id_valid    = ($urandom_range(99) < 80);
      id_rs       = 5'($urandom_range(7));
      id_rt       = 5'($urandom_range(7));
      ex_memrd    = ($urandom_range(99) < 30);
      ex_rt       = 5'($urandom_range(7));
      ex_br_taken = ($urandom_range(99) < 10);
      pc_kernel   = ($urandom_range(99) < 15);
      irq         = ($urandom_range(99) < 15) ? 4'($urandom) : 4'd0;
      irq_mask    = 4'($urandom);
      reset       = ($urandom_range(99) < 2);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_pipe_ctrl.md
Name: cpu_pipe_ctrl

Overview:
Pipelined successor to the single-cycle CPU control decoder. It decodes the instruction in ID and registers a control bundle into EX. It also detects load-use hazards, redirects the PC on jump/branch/trap, and runs an interrupt/exception sequencer over NUM_IRQ prioritised interrupt lines. It sits between the IF/ID register and the EX stage of the 5-stage datapath.

Parameters:
NUM_IRQ, 4, number of external interrupt lines (1..16); index 0 has the highest priority
HAZARD_EN, 1, 1 = hardware load-use interlock; 0 = no stall is ever generated

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
opcode  in  6  ID opcode
funct  in  6  ID funct
id_rs  in  5  ID rs field
id_rt  in  5  ID rt field
ex_memrd  in  1  EX instruction is lw
ex_rt  in  5  EX destination register of the lw
ex_br_taken  in  1  branch in EX resolved taken
pc_kernel  in  1  PC[31], kernel mode
irq  in  NUM_IRQ  level interrupt requests
irq_mask  in  NUM_IRQ  1 = line masked
stall  out  1  hold PC and IF/ID
flush_if  out  1  squash IF/ID
pcsrc  out  3  000 PC+4, 001 branch, 010 j/jal, 011 jr/jalr, 100 IRQ vector, 101 EXC vector
irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge
exc_cause  out  2  0 none, 1 undefined instruction, 2 interrupt (registered)
ex_regwr, ex_memwr, ex_memrd_o, ex_alusrc1, ex_alusrc2, ex_sign, ex_extop, ex_luop  out  1 each  registered EX control
ex_regdst  out  2  00 rd, 01 rt, 10 $ra, 11 $k0
ex_memtoreg  out  2  00 ALU, 01 mem, 10 PC
ex_alufun  out  6  ALU function

Behaviour:
- Decoded set: R-type add/addu/sub/subu/and/or/xor/nor/slt/sll/srl/sra/jr/jalr, plus lw/sw/lui/addi/addiu/andi/slti/sltiu/beq/bne/blez/bgtz/bltz/j/jal. Any other opcode/funct with id_valid=1 is undefined.
- ALUFun codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GTZ 111111, LTZ 111011.
- Control polarity:
  - ex_sign=0 only for addu/subu/addiu/sltiu.
  - ex_extop=0 only for andi.
  - ex_alusrc1=1 for sll/srl.
  - ex_alusrc2=1 for I-type ALU ops and lw/sw.
- Reset: every output is 0, FSM goes to IDLE, exc_cause=0.
- Bundle latency: 1 cycle (decode in cycle N appears on ex_* in cycle N+1).
- Bubble: all ex_* = 0. A bubble is inserted when stall=1, ex_br_taken=1, id_valid=0, or a trap is taken.
- Load-use stall (combinational): stall = HAZARD_EN & ex_memrd & id_valid & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt). The stall lasts exactly 1 cycle, because the bubble clears EX.
- Jump in ID (j/jal/jr/jalr, not stalled): pcsrc=010 or 011 and flush_if=1 for 1 cycle. jal/jalr write $ra with ex_regdst=10 and ex_memtoreg=10.
- ex_br_taken: pcsrc=001 and flush_if=1. The ID instruction is squashed; an exception or jump in ID is ignored that cycle.
- pcsrc priority: branch taken > exception take > interrupt take > jump in ID > PC+4.
- Sequencer states:
  - IDLE: if (irq & ~irq_mask)!=0 and pc_kernel=0, latch the lowest set index and go to ARM.
  - ARM: wait until id_valid=1, stall=0 and ex_br_taken=0, then go to TAKE.
  - TAKE (1 cycle): pcsrc=100, flush_if=1, irq_ack[idx]=1, exc_cause<=2. The EX trap bundle is ex_regwr=1, ex_regdst=11, ex_memtoreg=10, all other ex_* = 0. Then return to IDLE.
  - The request is sampled only at IDLE; deassertion during ARM does not cancel.
- Exception: undefined instruction in ID with id_valid=1, pc_kernel=0, no stall and no branch flush.
  - Takes immediately: pcsrc=101, flush_if=1, trap bundle, exc_cause<=1.
  - Legal from any state; ARM stays ARM, and the interrupt is taken later.
  - In kernel mode, an undefined instruction decodes as a bubble with no trap.
- Interrupts are not recognised while pc_kernel=1.
- Reset mid-ARM or mid-TAKE: returns to IDLE and no irq_ack is issued.
- NUM_IRQ=1: priority logic degenerates; irq_ack is 1 bit.

Test Plan:
1. addu $3,$1,$2 (op 0, funct 21) with id_valid=1 -> next cycle ex_regwr=1, ex_regdst=00, ex_alufun=000000, ex_sign=0; stall=0.
2. lw $5 in EX (ex_memrd=1, ex_rt=5), ID add with id_rs=5 -> stall=1 for 1 cycle and ex_* bubble; same stimulus with HAZARD_EN=0 -> stall=0.
3. ex_br_taken=1 while ID holds opcode 0x3F -> pcsrc=001, flush_if=1, exc_cause unchanged (0).
4. irq=4'b0110, irq_mask=0, pc_kernel=0, ID stalled for 1 cycle -> TAKE one cycle after the stall clears: pcsrc=100, irq_ack=4'b0010, ex_regdst=11, ex_memtoreg=10, exc_cause=2.
5. Undefined opcode 0x3F and pending interrupt in the same cycle -> pcsrc=101, exc_cause=1, irq_ack=0; interrupt TAKE on the next valid ID cycle.
6. Assert reset while in ARM -> all outputs 0 next cycle; no irq_ack until irq is re-sampled in IDLE.
